// File: rtl/tlp_dest_fork.sv
// Packet-level fork for the RQ stream: latches a route on each first beat and
// steers the packet to m0/m1/m2, or to both m1 and m2 for multicast.
module tlp_dest_fork #(
  parameter int TDATA_WIDTH    = 128,
  parameter int TKEEP_WIDTH    = 4,
  parameter int RQ_TUSER_WIDTH = 85,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic [TDATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic [RQ_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [1:0]                s_axis_tdest,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,

  output logic [TDATA_WIDTH-1:0]    m0_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]    m0_axis_tkeep,
  output logic                      m0_axis_tlast,
  output logic [RQ_TUSER_WIDTH-1:0] m0_axis_tuser,
  output logic                      m0_axis_tvalid,
  input  logic                      m0_axis_tready,

  output logic [TDATA_WIDTH-1:0]    m1_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]    m1_axis_tkeep,
  output logic                      m1_axis_tlast,
  output logic [RQ_TUSER_WIDTH-1:0] m1_axis_tuser,
  output logic                      m1_axis_tvalid,
  input  logic                      m1_axis_tready,

  output logic [TDATA_WIDTH-1:0]    m2_axis_tdata,
  output logic [TKEEP_WIDTH-1:0]    m2_axis_tkeep,
  output logic                      m2_axis_tlast,
  output logic [RQ_TUSER_WIDTH-1:0] m2_axis_tuser,
  output logic                      m2_axis_tvalid,
  input  logic                      m2_axis_tready,

  output logic [CNT_WIDTH-1:0]      pkt_cnt_0,
  output logic [CNT_WIDTH-1:0]      pkt_cnt_1,
  output logic [CNT_WIDTH-1:0]      pkt_cnt_2,
  output logic                      in_packet
);

  typedef enum logic [0:0] {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

  // tdest to port mask; 2'b11 is the m1+m2 multicast
  function automatic logic [2:0] decode_route(input logic [1:0] dest);
    logic [2:0] mask;
    case (dest)
      2'b00:   mask = 3'b001;
      2'b01:   mask = 3'b010;
      2'b10:   mask = 3'b100;
      2'b11:   mask = 3'b110;
      default: mask = 3'b001;
    endcase
    return mask;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [2:0]           cur_mask_r;
  logic [2:0]           done_r;
  logic [CNT_WIDTH-1:0] cnt_r [3];

  logic [2:0]           eff_mask_s;
  logic [2:0]           m_ready_s;
  logic [2:0]           port_ok_s;
  logic [2:0]           m_valid_s;
  logic [2:0]           take_s;
  logic                 in_ready_s;
  logic                 consume_s;

  assign m0_axis_tdata = s_axis_tdata;
  assign m0_axis_tkeep = s_axis_tkeep;
  assign m0_axis_tlast = s_axis_tlast;
  assign m0_axis_tuser = s_axis_tuser;
  assign m1_axis_tdata = s_axis_tdata;
  assign m1_axis_tkeep = s_axis_tkeep;
  assign m1_axis_tlast = s_axis_tlast;
  assign m1_axis_tuser = s_axis_tuser;
  assign m2_axis_tdata = s_axis_tdata;
  assign m2_axis_tkeep = s_axis_tkeep;
  assign m2_axis_tlast = s_axis_tlast;
  assign m2_axis_tuser = s_axis_tuser;

  assign pkt_cnt_0 = cnt_r[0];
  assign pkt_cnt_1 = cnt_r[1];
  assign pkt_cnt_2 = cnt_r[2];

  // Route, per-port valid and input ready; ports that already took the beat
  // stop offering it and no longer hold back consumption.
  always_comb begin
    eff_mask_s = 3'b000;
    if (state_r == ST_SOP) begin
      eff_mask_s = decode_route(s_axis_tdest);
    end else begin
      eff_mask_s = cur_mask_r;
    end
    m_ready_s = {m2_axis_tready, m1_axis_tready, m0_axis_tready};
    port_ok_s = ~eff_mask_s | done_r | m_ready_s;
    if (aresetn && s_axis_tvalid) begin
      m_valid_s = eff_mask_s & ~done_r;
    end else begin
      m_valid_s = 3'b000;
    end
    in_ready_s = aresetn & (&port_ok_s);
    consume_s  = s_axis_tvalid & in_ready_s;
    take_s     = m_valid_s & m_ready_s;
  end

  // Packet-phase state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= ST_SOP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Packet-phase next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SOP: begin
        if (consume_s && !s_axis_tlast) begin
          state_nxt_s = ST_BODY;
        end else begin
          state_nxt_s = ST_SOP;
        end
      end
      ST_BODY: begin
        if (consume_s && s_axis_tlast) begin
          state_nxt_s = ST_SOP;
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      default: state_nxt_s = ST_SOP;
    endcase
  end

  // Packet-phase outputs
  always_comb begin
    in_packet      = (state_r == ST_BODY);
    s_axis_tready  = in_ready_s;
    m0_axis_tvalid = m_valid_s[0];
    m1_axis_tvalid = m_valid_s[1];
    m2_axis_tvalid = m_valid_s[2];
  end

  // Frozen route and per-beat delivery bookkeeping
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cur_mask_r <= 3'b000;
      done_r     <= 3'b000;
    end else if (consume_s) begin
      done_r <= 3'b000;
      if (!s_axis_tlast) begin
        cur_mask_r <= eff_mask_s;
      end else begin
        cur_mask_r <= cur_mask_r;
      end
    end else if (s_axis_tvalid) begin
      done_r <= done_r | take_s;
    end else begin
      done_r <= done_r;
    end
  end

  // Per-port completed-packet counters, wrapping at all-ones
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int n = 0; n < 3; n++) begin
        cnt_r[n] <= '0;
      end
    end else if (consume_s && s_axis_tlast) begin
      for (int n = 0; n < 3; n++) begin
        if (eff_mask_s[n]) begin
          cnt_r[n] <= cnt_r[n] + CNT_ONE;
        end else begin
          cnt_r[n] <= cnt_r[n];
        end
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        cnt_r[n] <= cnt_r[n];
      end
    end
  end

endmodule

// File: tb/tb_tlp_dest_fork.sv
// Directed bench for tlp_dest_fork: one task per scenario, inline checks.
module tb_tlp_dest_fork;

  logic         aclk;
  logic         aresetn;
  logic [127:0] s_axis_tdata;
  logic [3:0]   s_axis_tkeep;
  logic         s_axis_tlast;
  logic [84:0]  s_axis_tuser;
  logic [1:0]   s_axis_tdest;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] m0_axis_tdata, m1_axis_tdata, m2_axis_tdata;
  logic [3:0]   m0_axis_tkeep, m1_axis_tkeep, m2_axis_tkeep;
  logic         m0_axis_tlast, m1_axis_tlast, m2_axis_tlast;
  logic [84:0]  m0_axis_tuser, m1_axis_tuser, m2_axis_tuser;
  logic         m0_axis_tvalid, m1_axis_tvalid, m2_axis_tvalid;
  logic         m0_axis_tready, m1_axis_tready, m2_axis_tready;
  logic [3:0]   pkt_cnt_0, pkt_cnt_1, pkt_cnt_2;
  logic         in_packet;

  int total = 0;
  int bad   = 0;

  tlp_dest_fork #(
    .TDATA_WIDTH(128), .TKEEP_WIDTH(4), .RQ_TUSER_WIDTH(85), .CNT_WIDTH(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tdest(s_axis_tdest), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tkeep(m0_axis_tkeep),
    .m0_axis_tlast(m0_axis_tlast), .m0_axis_tuser(m0_axis_tuser),
    .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tkeep(m1_axis_tkeep),
    .m1_axis_tlast(m1_axis_tlast), .m1_axis_tuser(m1_axis_tuser),
    .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
    .m2_axis_tdata(m2_axis_tdata), .m2_axis_tkeep(m2_axis_tkeep),
    .m2_axis_tlast(m2_axis_tlast), .m2_axis_tuser(m2_axis_tuser),
    .m2_axis_tvalid(m2_axis_tvalid), .m2_axis_tready(m2_axis_tready),
    .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .pkt_cnt_2(pkt_cnt_2),
    .in_packet(in_packet)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic drive(input logic v, input logic [1:0] d, input logic l,
                       input logic [127:0] dat, input logic [2:0] rdy);
    s_axis_tvalid = v;
    s_axis_tdest  = d;
    s_axis_tlast  = l;
    s_axis_tdata  = dat;
    {m2_axis_tready, m1_axis_tready, m0_axis_tready} = rdy;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    drive(1'b1, 2'b11, 1'b0, 128'h0, 3'b111);
    @(negedge aclk);
    #1;
    total++;
    if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000",
               {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
    end
    total++;
    if ({in_packet, pkt_cnt_2, pkt_cnt_1, pkt_cnt_0} !== 13'h0000) begin
      bad++;
      $display("FAIL reset_state: got in_packet=%b cnt=%h/%h/%h want 0 0/0/0",
               in_packet, pkt_cnt_2, pkt_cnt_1, pkt_cnt_0);
    end
    aresetn = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    @(negedge aclk);
  endtask

  task automatic test_unicast();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, (i == 2), 128'(i + 5), 3'b111);
      #1;
      total++;
      if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b0101) begin
        bad++;
        $display("FAIL unicast_valid beat%0d: got %b want 0101", i,
                 {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
      end
      total++;
      if (m1_axis_tdata !== 128'(i + 5)) begin
        bad++;
        $display("FAIL unicast_data beat%0d: got %h want %h", i, m1_axis_tdata, 128'(i + 5));
      end
      total++;
      if (in_packet !== (i != 0)) begin
        bad++;
        $display("FAIL unicast_in_packet beat%0d: got %b want %b", i, in_packet, (i != 0));
      end
      @(negedge aclk);
    end
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    #1;
    total++;
    if ({in_packet, pkt_cnt_2, pkt_cnt_1, pkt_cnt_0} !== 13'h0010) begin
      bad++;
      $display("FAIL unicast_end: got in_packet=%b cnt=%h/%h/%h want 0 0/1/0",
               in_packet, pkt_cnt_2, pkt_cnt_1, pkt_cnt_0);
    end
    @(negedge aclk);
  endtask

  task automatic test_multicast_skew();
    do_reset();
    drive(1'b1, 2'b11, 1'b0, 128'hA0, 3'b011);
    #1;
    total++;
    if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b1100) begin
      bad++;
      $display("FAIL mcast_cycle0: got %b want 1100",
               {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
    end
    @(negedge aclk);
    #1;
    total++;
    if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready, in_packet} !== 5'b10000) begin
      bad++;
      $display("FAIL mcast_cycle1: got %b want 10000",
               {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready, in_packet});
    end
    @(negedge aclk);
    drive(1'b1, 2'b11, 1'b0, 128'hA0, 3'b111);
    #1;
    total++;
    if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b1001) begin
      bad++;
      $display("FAIL mcast_m2_accept: got %b want 1001",
               {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
    end
    @(negedge aclk);
    drive(1'b1, 2'b00, 1'b1, 128'hA1, 3'b111);
    #1;
    total++;
    if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready, in_packet} !== 5'b11011) begin
      bad++;
      $display("FAIL mcast_last_beat: got %b want 11011",
               {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready, in_packet});
    end
    total++;
    if (m2_axis_tuser !== s_axis_tuser) begin
      bad++;
      $display("FAIL mcast_tuser: got %h want %h", m2_axis_tuser, 85'h1A5);
    end
    @(negedge aclk);
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    #1;
    total++;
    if ({pkt_cnt_2, pkt_cnt_1, pkt_cnt_0} !== 12'h110) begin
      bad++;
      $display("FAIL mcast_counts: got %h/%h/%h want 1/1/0", pkt_cnt_2, pkt_cnt_1, pkt_cnt_0);
    end
    @(negedge aclk);
  endtask

  task automatic test_mid_packet_dest();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 2'b10 : 2'b00, (i == 3), 128'(i), 3'b111);
      #1;
      total++;
      if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b1001) begin
        bad++;
        $display("FAIL middest_valid beat%0d: got %b want 1001", i,
                 {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
      end
      @(negedge aclk);
    end
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    #1;
    total++;
    if ({pkt_cnt_2, pkt_cnt_1, pkt_cnt_0} !== 12'h100) begin
      bad++;
      $display("FAIL middest_counts: got %h/%h/%h want 1/0/0", pkt_cnt_2, pkt_cnt_1, pkt_cnt_0);
    end
    @(negedge aclk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_mask [4];
    exp_mask[0] = 3'b001;
    exp_mask[1] = 3'b010;
    exp_mask[2] = 3'b100;
    exp_mask[3] = 3'b110;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b1, 128'(i), 3'b111);
      #1;
      total++;
      if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready, in_packet} !==
          {exp_mask[i], 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL b2b_route dest%0d: got %b want %b", i,
                 {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready, in_packet},
                 {exp_mask[i], 1'b1, 1'b0});
      end
      @(negedge aclk);
    end
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    #1;
    total++;
    if ({pkt_cnt_2, pkt_cnt_1, pkt_cnt_0} !== 12'h221) begin
      bad++;
      $display("FAIL b2b_counts: got %h/%h/%h want 2/2/1", pkt_cnt_2, pkt_cnt_1, pkt_cnt_0);
    end
    @(negedge aclk);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b01, 1'b0, 128'(i), 3'b111);
      #1;
      total++;
      if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b0101) begin
        bad++;
        $display("FAIL rstmid_beat%0d: got %b want 0101", i,
                 {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
      end
      @(negedge aclk);
    end
    aresetn = 1'b0;
    drive(1'b0, 2'b01, 1'b0, 128'h0, 3'b111);
    @(negedge aclk);
    total++;
    if ({in_packet, pkt_cnt_2, pkt_cnt_1, pkt_cnt_0} !== 13'h0000) begin
      bad++;
      $display("FAIL rstmid_state: got in_packet=%b cnt=%h/%h/%h want 0 0/0/0",
               in_packet, pkt_cnt_2, pkt_cnt_1, pkt_cnt_0);
    end
    aresetn = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 128'h10, 3'b111);
    #1;
    total++;
    if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b0011) begin
      bad++;
      $display("FAIL rstmid_reroute: got %b want 0011",
               {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
    end
    @(negedge aclk);
    drive(1'b1, 2'b01, 1'b1, 128'h11, 3'b111);
    #1;
    total++;
    if ({m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready} !== 4'b0011) begin
      bad++;
      $display("FAIL rstmid_tail: got %b want 0011",
               {m2_axis_tvalid, m1_axis_tvalid, m0_axis_tvalid, s_axis_tready});
    end
    @(negedge aclk);
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    #1;
    total++;
    if ({pkt_cnt_2, pkt_cnt_1, pkt_cnt_0} !== 12'h001) begin
      bad++;
      $display("FAIL rstmid_counts: got %h/%h/%h want 0/0/1", pkt_cnt_2, pkt_cnt_1, pkt_cnt_0);
    end
    @(negedge aclk);
  endtask

  task automatic test_counter_wrap();
    logic [3:0] exp_cnt;
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 2'b00, 1'b1, 128'(i), 3'b111);
      @(negedge aclk);
      if (i >= 15) begin
        exp_cnt = i[3:0];
        total++;
        if (pkt_cnt_0 !== exp_cnt) begin
          bad++;
          $display("FAIL wrap_cnt after pkt%0d: got %0d want %0d", i, pkt_cnt_0, exp_cnt);
        end
      end
    end
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    @(negedge aclk);
  endtask

  initial begin
    aresetn      = 1'b0;
    s_axis_tkeep = 4'hF;
    s_axis_tuser = 85'h1A5;
    drive(1'b0, 2'b00, 1'b0, 128'h0, 3'b111);
    @(negedge aclk);
    test_reset();
    test_unicast();
    test_multicast_skew();
    test_mid_packet_dest();
    test_back_to_back();
    test_reset_mid_packet();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlp_dest_fork.md
# tlp_dest_fork

Packet-level demultiplexer/fork placed directly downstream of the bridge's routing stage. It takes the RQ-format stream with its 2-bit `tdest`, latches the route on each packet's first beat, and steers the whole packet to one of three master ports. A `tdest` of 2'b11 duplicates the packet to two ports, with per-port bookkeeping so each beat is delivered exactly once per destination. Per-port packet counters are provided for debug.

## Interface
- `TDATA_WIDTH`, default 128: data width of all streams.
- `TKEEP_WIDTH`, default 4: keep width (dword granularity).
- `RQ_TUSER_WIDTH`, default 85: tuser width, passed through unchanged.
- `CNT_WIDTH`, default 16: width of each packet counter.

Ports:
- `aclk`  in  1  clock; all logic is on its rising edge.
- `aresetn`  in  1  synchronous, active-low reset.
- `s_axis_tdata`/`tkeep`/`tlast`/`tuser`  in  TDATA_WIDTH/TKEEP_WIDTH/1/RQ_TUSER_WIDTH  input beat.
- `s_axis_tdest`  in  2  route; sampled only on the first beat of a packet.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `mN_axis_tdata`/`tkeep`/`tlast`/`tuser`, N=0,1,2  out  same widths  copies of the input beat fields.
- `mN_axis_tvalid`  out  1  per-port valid.
- `mN_axis_tready`  in  1  per-port ready.
- `pkt_cnt_N`, N=0,1,2  out  CNT_WIDTH  packets completed on port N.
- `in_packet`  out  1  high between an accepted non-last beat and its packet's tlast.

## Operation
- **Route decode (3-bit mask, bit N selects mN):**
  - tdest 2'b00 -> 3'b001 (m0, upstream/default).
  - 2'b01 -> 3'b010 (m1).
  - 2'b10 -> 3'b100 (m2).
  - 2'b11 -> 3'b110 (multicast to m1 and m2).
- **State registers:**
  - `sop` (1 = next beat is a first beat).
  - `cur_mask[2:0]`.
  - `done[2:0]` (port already took the current beat).
  - Three counters.
- **Effective mask:** `eff_mask = sop ? decode(s_axis_tdest) : cur_mask`.
- **Beat broadcast:** data, keep, last and user drive all three master ports unchanged and combinationally. `mN_axis_tvalid = s_axis_tvalid & eff_mask[N] & ~done[N]`.
- **Input ready:** `s_axis_tready` = AND over N of `(~eff_mask[N] | done[N] | mN_axis_tready)`.
- **Beat consumed:** `s_axis_tvalid & s_axis_tready`. On consume:
  - `done` <= 0.
  - If tlast: `sop` <= 1.
  - Otherwise: `sop` <= 0 and `cur_mask` <= `eff_mask`.
- **Partial acceptance (valid, not consumed):** `done[N]` <= 1 for every port with `mN_axis_tvalid & mN_axis_tready`. Other done bits hold.
- **States:**
  - SOP (`sop`=1): route follows `tdest` live.
  - BODY (`sop`=0): route is frozen. `tdest` changes in BODY are ignored.
- **Counters:** on a consumed tlast beat, `pkt_cnt_N` increments by 1 for each N in `eff_mask`. Counters wrap modulo 2^CNT_WIDTH (all-ones -> 0).
- `in_packet` = `~sop`.
- **Stall rules:**
  - A stalled multicast port never blocks the other from taking a beat. It only blocks consumption.
  - Valid must not drop on a port until that port accepts or the beat is consumed.

## Timing
- Zero-cycle latency: the input-to-output path is combinational. Ready is combinational from the mN readies.
- Throughput:
  - Unicast: one beat per cycle.
  - Multicast: one beat per cycle when both ports are ready.
  - Multicast, ports ready in different cycles: the beat is consumed in the cycle the last outstanding port accepts.
- Reset (aresetn low at a clock edge):
  - `sop`=1, `cur_mask`=0, `done`=0, all `pkt_cnt_N`=0, `in_packet`=0.
  - Outputs while reset is held: all `mN_axis_tvalid`=0 and `s_axis_tready`=0.
- Reset mid-packet: the partial packet is abandoned, with no counter update. The first beat after reset is treated as SOP.
- Single-beat packet: `sop` stays 1, and the next cycle re-decodes `tdest`.
- `s_axis_tvalid` low: no state change; `done` holds.

## Test plan
1. **Unicast 3-beat packet:** `tdest`=2'b01, all readies 1 -> m1 sees 3 valid beats on consecutive cycles; m0 and m2 valid stay 0; `pkt_cnt_1`=1; `in_packet` high for exactly 2 cycles.
2. **Multicast with skew:** `tdest`=2'b11, m1_tready=1 and m2_tready=0 for 2 cycles then 1 -> m1 accepts beat 0 once, with m1_tvalid low after its handshake; `s_axis_tready` rises only in m2's accept cycle; both counters = 1.
3. **Mid-packet tdest change:** `tdest`=2'b10 on beat 0, 2'b00 on beats 1-3 -> all 4 beats on m2, none on m0; `pkt_cnt_2`=1.
4. **Back-to-back single-beat packets:** `tdest` 00, 01, 10, 11 on consecutive cycles with tlast=1 -> delivered to m0, m1, m2, then m1+m2; final counts 1/2/2.
5. **Reset mid-packet:** assert aresetn=0 after beat 1 of a 4-beat packet to m1 -> counters = 0, `in_packet`=0; the next beat, with `tdest`=00, routes to m0.
6. **Counter wrap (CNT_WIDTH=4):** 17 single-beat packets to m0 -> `pkt_cnt_0` reads 15 after the 15th packet, 0 after the 16th, 1 after the 17th.
